adc_sequencer: RTL

ADC_SEQUENCER -- requirements
Module: adc_sequencer

---
 rtl/adc_seq_pkg.sv | 40 ++++
 rtl/adc_seq_accum.sv | 73 +++++++
 rtl/adc_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the MAX10 ADC sequencer: FSM state encoding, bit
// positions of the result word fields, and a helper that assembles a result
// word from its fields.
// -----------------------------------------------------------------------------
package adc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        PRESENT   = 2'd3
    } seq_state_e;

    // Result word layout
    localparam int OD_MISMATCH_BIT = 31;
    localparam int OD_TIMEOUT_BIT  = 30;
    localparam int OD_CH_LSB       = 16;
    localparam int OD_CH_W         = 5;
    localparam int OD_DATA_LSB     = 0;
    localparam int OD_DATA_W       = 12;

    // Build a result word; all reserved bits are zero.
    function automatic logic [31:0] pack_word(
        input logic        mismatch,
        input logic        timeout,
        input logic [4:0]  ch,
        input logic [11:0] data
    );
        logic [31:0] w;
        w                              = 32'd0;
        w[OD_MISMATCH_BIT]             = mismatch;
        w[OD_TIMEOUT_BIT]              = timeout;
        w[OD_CH_LSB +: OD_CH_W]        = ch;
        w[OD_DATA_LSB +: OD_DATA_W]    = data;
        return w;
    endfunction

endpackage

// File: rtl/adc_seq_accum.sv
// -----------------------------------------------------------------------------
// adc_seq_accum
// Sample accumulator for the ADC sequencer. Sums 2^AVG_LOG2 unsigned 12-bit
// samples and reports the truncated average, including the sample currently
// being added, so the result is available in the same cycle as the final
// sample.
//
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset
//   clear_i  in   clear sum and count (result word handed off)
//   add_i    in   add data_i to the sum, bump the count
//   data_i   in   12-bit sample
//   last_o   out  the sample being offered now is the final one of the word
//   avg_o    out  (sum + data_i) >> AVG_LOG2
// -----------------------------------------------------------------------------
module adc_seq_accum #(
    parameter int AVG_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        add_i,
    input  logic [11:0] data_i,
    output logic        last_o,
    output logic [11:0] avg_o
);

    // Wide enough that 2^AVG_LOG2 full-scale samples can never overflow.
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0] sum_shift_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sum_s       = acc_q + ACC_W'(data_i);
    assign sum_shift_s = sum_s >> AVG_LOG2;
    assign avg_o       = sum_shift_s[11:0];
    assign last_o      = (cnt_q == LAST_CNT);

    // Next-state for sum and sample count; clear wins over add.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            acc_d = sum_s;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end
    end

    // Sum and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// -----------------------------------------------------------------------------
// adc_sequencer
// Scans MAX10 ADC channels FIRST_CHANNEL..FIRST_CHANNEL+NUM_CHANNELS-1 one
// command at a time, collects the matching responses and hands one 32-bit
// result word per channel to the CPU stream.
//
// Build option: define ADC_SEQ_AVERAGE_EN to average 2^AVG_LOG2 samples per
// word (adc_seq_accum). Without it each word carries a single raw sample and
// AVG_LOG2 has no effect.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   command_valid/_channel/
//   _startofpacket/_endofpacket  single-beat ADC command (registered)
//   command_ready              ADC accepts command
//   response_valid/_channel/
//   _data                      ADC sample
//   out_data, out_stb          result word and its valid (registered)
//   out_ack                    CPU accepts the word
//
// Result word: [31] foreign-channel response seen, [30] a command timed out,
// [20:16] channel, [11:0] sample or average.
// -----------------------------------------------------------------------------
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int FIRST_CHANNEL = 1,
    parameter int NUM_CHANNELS  = 4,
    parameter int AVG_LOG2      = 3,
    parameter int TIMEOUT       = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        command_valid,
    output logic [4:0]  command_channel,
    output logic        command_startofpacket,
    output logic        command_endofpacket,
    input  logic        command_ready,
    input  logic        response_valid,
    input  logic [4:0]  response_channel,
    input  logic [11:0] response_data,
    output logic [31:0] out_data,
    output logic        out_stb,
    input  logic        out_ack
);

    localparam logic [4:0] FIRST_CH_C = 5'(FIRST_CHANNEL);
    localparam logic [4:0] LAST_CH_C  = 5'(FIRST_CHANNEL + NUM_CHANNELS - 1);
    // Counter walks 0..TIMEOUT-1; the TIMEOUT-th waiting cycle gives up.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TIMEOUT - 1);

    seq_state_e        state_q;
    seq_state_e        state_d;
    logic              cmd_valid_q;
    logic              cmd_valid_d;
    logic [4:0]        cmd_channel_q;
    logic [4:0]        cmd_channel_d;
    logic              out_stb_q;
    logic              out_stb_d;
    logic [31:0]       out_data_q;
    logic [31:0]       out_data_d;
    logic              mismatch_q;
    logic              mismatch_d;
    logic              timeout_q;
    logic              timeout_d;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_d;

    logic              match_s;
    logic              last_s;
    logic [11:0]       avg_s;
    logic              acc_add_s;
    logic              acc_clear_s;

    assign match_s = response_valid && (response_channel == cmd_channel_q);

`ifdef ADC_SEQ_AVERAGE_EN
    adc_seq_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (acc_clear_s),
        .add_i   (acc_add_s),
        .data_i  (response_data),
        .last_o  (last_s),
        .avg_o   (avg_s)
    );
`else
    // One sample per word: every matching response completes the word.
    assign last_s = 1'b1;
    assign avg_s  = response_data;
    logic unused_accum_ctrl_s;
    assign unused_accum_ctrl_s = acc_add_s ^ acc_clear_s;
`endif

    // Next-state, flag, channel and result-word logic.
    always_comb begin
        state_d       = state_q;
        cmd_channel_d = cmd_channel_q;
        mismatch_d    = mismatch_q;
        timeout_d     = timeout_q;
        tmo_cnt_d     = tmo_cnt_q;
        out_data_d    = out_data_q;
        acc_add_s     = 1'b0;
        acc_clear_s   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = ISSUE;
            end

            ISSUE: begin
                tmo_cnt_d = '0;
                if (command_ready) begin
                    state_d = WAIT_RESP;
                end else begin
                    state_d = ISSUE;
                end
            end

            WAIT_RESP: begin
                // A matching response beats a timeout in the same cycle.
                if (match_s) begin
                    acc_add_s = 1'b1;
                    tmo_cnt_d = '0;
                    if (last_s) begin
                        state_d    = PRESENT;
                        out_data_d = pack_word(mismatch_q, timeout_q,
                                               cmd_channel_q, avg_s);
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (tmo_cnt_q == TMO_LAST_C) begin
                    timeout_d = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = ISSUE;
                    if (response_valid) begin
                        mismatch_d = 1'b1;
                    end else begin
                        mismatch_d = mismatch_q;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (response_valid) begin
                        mismatch_d = 1'b1;
                    end else begin
                        mismatch_d = mismatch_q;
                    end
                end
            end

            PRESENT: begin
                if (out_ack) begin
                    state_d     = ISSUE;
                    mismatch_d  = 1'b0;
                    timeout_d   = 1'b0;
                    acc_clear_s = 1'b1;
                    if (cmd_channel_q == LAST_CH_C) begin
                        cmd_channel_d = FIRST_CH_C;
                    end else begin
                        cmd_channel_d = cmd_channel_q + 5'd1;
                    end
                end else begin
                    state_d = PRESENT;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the state being entered.
        cmd_valid_d = (state_d == ISSUE);
        out_stb_d   = (state_d == PRESENT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_channel_q <= FIRST_CH_C;
            out_stb_q     <= 1'b0;
            out_data_q    <= 32'd0;
            mismatch_q    <= 1'b0;
            timeout_q     <= 1'b0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_channel_q <= cmd_channel_d;
            out_stb_q     <= out_stb_d;
            out_data_q    <= out_data_d;
            mismatch_q    <= mismatch_d;
            timeout_q     <= timeout_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    // Single-beat packets: SOP and EOP coincide with valid.
    assign command_valid         = cmd_valid_q;
    assign command_startofpacket = cmd_valid_q;
    assign command_endofpacket   = cmd_valid_q;
    assign command_channel       = cmd_channel_q;
    assign out_stb               = out_stb_q;
    assign out_data              = out_data_q;

endmodule
